// File: rtl/multi_roi_centroid.sv
// ============================================================================
//  Module      : multi_roi_centroid
//  Description : Streams a raster image and computes one x-centroid per
//                horizontal band (ROI) at the bottom of the frame. Contributing
//                pixels (pixel_in > THRESHOLD) are accumulated with weight 1 or
//                pixel_in. At each band end the sums go to a shared sequential
//                restoring divider. Per-band results are staged and published
//                together, one cycle after band 0 completes.
//  Ports       : clk         - clock
//                rst         - asynchronous active-low reset
//                pixel_in    - raster-order pixel (PIX_W bits)
//                in_ready    - pixel_in valid this cycle
//                centroid_x  - packed per-band centroids, band k at [k*CX_W +: CX_W]
//                roi_found   - per-band valid mask
//                heading     - signed centroid(NUM_ROI-1) - centroid(0)
//                frame_valid - one-cycle pulse when outputs update
//                line_lost   - high when no band is valid
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_roi_centroid #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int PIX_W      = 4,
    parameter int NUM_ROI    = 4,
    parameter int ROI_HEIGHT = 64,
    parameter int THRESHOLD  = 0,
    parameter int WEIGHTED   = 0,
    parameter int MIN_WEIGHT = 1,
    localparam int CX_W      = $clog2(IMG_W) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PIX_W-1:0]          pixel_in,
    input  logic                      in_ready,
    output logic [NUM_ROI*CX_W-1:0]   centroid_x,
    output logic [NUM_ROI-1:0]        roi_found,
    output logic signed [CX_W:0]      heading,
    output logic                      frame_valid,
    output logic                      line_lost
);

    localparam int X_W   = $clog2(IMG_W);
    localparam int Y_W   = $clog2(IMG_H);
    localparam int ACC_W = PIX_W + $clog2(IMG_W * ROI_HEIGHT) + 1;
    localparam int SXW_W = ACC_W + CX_W;
    localparam int CNT_W = $clog2(SXW_W + 1);
    localparam int B_W   = (NUM_ROI > 1) ? $clog2(NUM_ROI) : 1;

    localparam logic [X_W-1:0]   X_LAST  = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(IMG_H - 1);
    localparam logic [31:0]      THR_C   = 32'(THRESHOLD);
    localparam logic [ACC_W-1:0] MIN_W_C = ACC_W'(MIN_WEIGHT);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_STORE = 2'd2} state_t;

    state_t                    state_q;
    logic [X_W-1:0]            x_q;
    logic [Y_W-1:0]            y_q;
    logic [ACC_W-1:0]          sum_w_q, sum_w_d;
    logic [SXW_W-1:0]          sum_xw_q, sum_xw_d;
    logic [ACC_W-1:0]          rem_q, div_q;
    logic [SXW_W-1:0]          quo_q;       // dividend shifts out, quotient shifts in
    logic [CNT_W-1:0]          cnt_q;
    logic [B_W-1:0]            div_band_q;
    logic [NUM_ROI*CX_W-1:0]   stage_cx_q, stage_cx_d;
    logic [NUM_ROI-1:0]        stage_found_q, stage_found_d;
    logic [NUM_ROI*CX_W-1:0]   centroid_x_q;
    logic [NUM_ROI-1:0]        roi_found_q;
    logic [CX_W:0]             heading_q;
    logic                      frame_valid_q, line_lost_q;

    logic                      w_in_band, w_band_last, w_hit, w_band_end, w_band_ok;
    logic                      w_publish, w_ge;
    logic [B_W-1:0]            w_band;
    logic [ACC_W-1:0]          w_weight;
    logic [ACC_W:0]            w_trial, w_sub;
    logic [CX_W-1:0]           w_cx_top, w_cx_bot;
    logic [CX_W:0]             w_heading;
    logic [31:0]               w_y32;

    // Band lookup: band k spans rows IMG_H-(k+1)*ROI_HEIGHT .. IMG_H-k*ROI_HEIGHT-1.
    always_comb begin
        w_in_band   = 1'b0;
        w_band      = '0;
        w_band_last = 1'b0;
        w_y32       = 32'(y_q);
        for (int k = 0; k < NUM_ROI; k++) begin
            if ((w_y32 >= 32'(IMG_H - (k + 1) * ROI_HEIGHT)) &&
                (w_y32 <= 32'(IMG_H - k * ROI_HEIGHT - 1))) begin
                w_in_band   = 1'b1;
                w_band      = B_W'(k);
                w_band_last = (w_y32 == 32'(IMG_H - k * ROI_HEIGHT - 1));
            end
        end
    end

    always_comb begin
        w_hit    = in_ready && w_in_band && (32'(pixel_in) > THR_C);
        w_weight = '0;
        if (w_hit) begin
            w_weight = (WEIGHTED != 0) ? ACC_W'(pixel_in) : ACC_W'(1);
        end
        // Next sums include the current pixel so the band's last pixel is
        // part of what gets handed to the divider.
        sum_w_d    = sum_w_q + w_weight;
        sum_xw_d   = sum_xw_q + SXW_W'(x_q) * SXW_W'(w_weight);
        w_band_end = in_ready && w_in_band && w_band_last && (x_q == X_LAST);
        w_band_ok  = (sum_w_d >= MIN_W_C) && (sum_w_d != '0);

        // One restoring step: shift in the next dividend bit, subtract if it fits.
        w_trial = {rem_q, quo_q[SXW_W-1]};
        w_ge    = (w_trial >= {1'b0, div_q});
        w_sub   = w_trial - {1'b0, div_q};

        stage_cx_d    = stage_cx_q;
        stage_found_d = stage_found_q;
        w_publish     = 1'b0;
        if (state_q == S_STORE) begin
            stage_cx_d[int'(div_band_q) * CX_W +: CX_W] = quo_q[CX_W-1:0];
            stage_found_d[div_band_q]                   = 1'b1;
            w_publish                                   = (div_band_q == '0);
        end
        if (w_band_end && !w_band_ok) begin
            stage_cx_d[int'(w_band) * CX_W +: CX_W] = '0;
            stage_found_d[w_band]                   = 1'b0;
            w_publish                               = (w_band == '0);
        end

        w_cx_top  = stage_cx_d[(NUM_ROI - 1) * CX_W +: CX_W];
        w_cx_bot  = stage_cx_d[0 +: CX_W];
        w_heading = '0;
        if (stage_found_d[NUM_ROI-1] && stage_found_d[0]) begin
            w_heading = {1'b0, w_cx_top} - {1'b0, w_cx_bot};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            sum_w_q       <= '0;
            sum_xw_q      <= '0;
            rem_q         <= '0;
            div_q         <= '0;
            quo_q         <= '0;
            cnt_q         <= '0;
            div_band_q    <= '0;
            stage_cx_q    <= '0;
            stage_found_q <= '0;
            centroid_x_q  <= '0;
            roi_found_q   <= '0;
            heading_q     <= '0;
            frame_valid_q <= 1'b0;
            line_lost_q   <= 1'b1;
        end else begin
            if (in_ready) begin
                if (x_q == X_LAST) begin
                    x_q <= '0;
                    y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end

            if (w_band_end) begin
                sum_w_q  <= '0;
                sum_xw_q <= '0;
            end else begin
                sum_w_q  <= sum_w_d;
                sum_xw_q <= sum_xw_d;
            end

            stage_cx_q    <= stage_cx_d;
            stage_found_q <= stage_found_d;

            case (state_q)
                S_IDLE: begin
                    if (w_band_end && w_band_ok) begin
                        quo_q      <= sum_xw_d;
                        div_q      <= sum_w_d;
                        rem_q      <= '0;
                        cnt_q      <= '0;
                        div_band_q <= w_band;
                        state_q    <= S_DIV;
                    end
                end
                S_DIV: begin
                    rem_q <= w_ge ? w_sub[ACC_W-1:0] : w_trial[ACC_W-1:0];
                    quo_q <= {quo_q[SXW_W-2:0], w_ge};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(SXW_W - 1)) begin
                        state_q <= S_STORE;
                    end
                end
                S_STORE: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            frame_valid_q <= w_publish;
            if (w_publish) begin
                centroid_x_q <= stage_cx_d;
                roi_found_q  <= stage_found_d;
                heading_q    <= w_heading;
                line_lost_q  <= (stage_found_d == '0);
            end
        end
    end

    assign centroid_x  = centroid_x_q;
    assign roi_found   = roi_found_q;
    assign heading     = heading_q;
    assign frame_valid = frame_valid_q;
    assign line_lost   = line_lost_q;

endmodule

`default_nettype wire

// File: tb/tb_multi_roi_centroid.sv
// ============================================================================
//  Module      : tb_multi_roi_centroid
//  Description : Self-checking bench for multi_roi_centroid. Two instances
//                (unweighted with THRESHOLD=3, weighted with MIN_WEIGHT=10)
//                see the same pixel stream. Directed frames come from a table,
//                random frames are checked against a per-band arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_roi_centroid;

    localparam int W  = 32;
    localparam int H  = 24;
    localparam int NR = 4;
    localparam int RH = 4;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] pixel_in = '0;
    logic in_ready = 1'b0;

    logic [NR*CW-1:0] cx0, cx1;
    logic [NR-1:0]    f0, f1;
    logic signed [CW:0] hd0, hd1;
    logic fv0, fv1, ll0, ll1;

    always #5 clk = ~clk;

    multi_roi_centroid #(.IMG_W(W), .IMG_H(H), .PIX_W(4), .NUM_ROI(NR), .ROI_HEIGHT(RH),
                         .THRESHOLD(3), .WEIGHTED(0), .MIN_WEIGHT(1)) u0 (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_ready(in_ready),
        .centroid_x(cx0), .roi_found(f0), .heading(hd0), .frame_valid(fv0), .line_lost(ll0));

    multi_roi_centroid #(.IMG_W(W), .IMG_H(H), .PIX_W(4), .NUM_ROI(NR), .ROI_HEIGHT(RH),
                         .THRESHOLD(0), .WEIGHTED(1), .MIN_WEIGHT(10)) u1 (
        .clk(clk), .rst(rst), .pixel_in(pixel_in), .in_ready(in_ready),
        .centroid_x(cx1), .roi_found(f1), .heading(hd1), .frame_valid(fv1), .line_lost(ll1));

    int vectors = 0;
    int miscompares = 0;

    logic [3:0] img [H][W];

    // frame_valid monitor: counts pulses and captures what was published.
    int fvc0 = 0, fvc1 = 0;
    logic [NR*CW-1:0] cap_cx0, cap_cx1;
    logic [NR-1:0]    cap_f0, cap_f1;
    logic [CW:0]      cap_hd0, cap_hd1;
    logic             cap_ll0, cap_ll1;

    always @(negedge clk) begin
        if (fv0) begin
            fvc0 <= fvc0 + 1; cap_cx0 <= cx0; cap_f0 <= f0; cap_hd0 <= hd0; cap_ll0 <= ll0;
        end
        if (fv1) begin
            fvc1 <= fvc1 + 1; cap_cx1 <= cx1; cap_f1 <= f1; cap_hd1 <= hd1; cap_ll1 <= ll1;
        end
    end

    typedef struct {
        int               pat;
        logic [NR*CW-1:0] ecx0; logic [NR-1:0] ef0; int ehd0; logic ell0;
        logic [NR*CW-1:0] ecx1; logic [NR-1:0] ef1; int ehd1; logic ell1;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [CW:0] v);
        return {{(31-CW){v[CW]}}, v};
    endfunction

    function automatic logic [NR*CW-1:0] pack4(input int c3, input int c2, input int c1, input int c0);
        return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
    endfunction

    task automatic clear_img();
        for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) img[y][x] = 4'd0;
    endtask

    task automatic build_pattern(input int p);
        clear_img();
        case (p)
            0: for (int y = 0; y < H; y++) for (int x = 14; x <= 17; x++) img[y][x] = 4'd15;
            1: ;
            2: begin
                for (int y = 20; y < 24; y++) img[y][5]  = 4'd15;
                for (int y = 8;  y < 12; y++) img[y][27] = 4'd15;
            end
            3: begin img[22][10] = 4'd15; img[22][20] = 4'd5; end
            default: begin
                for (int x = 2; x <= 10; x++) img[12][x] = 4'd1;
                for (int x = 0; x <= 9;  x++) img[17][x] = 4'd1;
                img[9][7] = 4'd3;
                img[9][9] = 4'd4;
            end
        endcase
    endtask

    // Reference: per band, sum weights and x*weight over its rows, then divide.
    task automatic model(input int thr, input bit wt, input int minw,
                         output logic [NR*CW-1:0] cx, output logic [NR-1:0] f,
                         output int hd, output logic ll);
        int sw, sxw, top, v, wgt, c3, c0;
        cx = '0; f = '0;
        for (int k = 0; k < NR; k++) begin
            top = H - (k + 1) * RH;
            sw = 0; sxw = 0;
            for (int r = top; r < top + RH; r++) begin
                for (int x = 0; x < W; x++) begin
                    v = int'(img[r][x]);
                    if (v > thr) begin
                        wgt = wt ? v : 1;
                        sw += wgt;
                        sxw += x * wgt;
                    end
                end
            end
            if (sw >= minw && sw > 0) begin
                f[k] = 1'b1;
                cx[k*CW +: CW] = CW'(sxw / sw);
            end
        end
        c3 = int'(cx[3*CW +: CW]);
        c0 = int'(cx[0 +: CW]);
        hd = (f[3] && f[0]) ? (c3 - c0) : 0;
        ll = (f == '0);
    endtask

    task automatic chk_reset_state(input string tag);
        @(negedge clk);
        chk({tag, " rst cx0"}, 32'(cx0), 32'd0);
        chk({tag, " rst f0"},  32'(f0), 32'd0);
        chk({tag, " rst hd0"}, sx(hd0), 32'd0);
        chk({tag, " rst fv0"}, 32'(fv0), 32'd0);
        chk({tag, " rst ll0"}, 32'(ll0), 32'd1);
        chk({tag, " rst cx1"}, 32'(cx1), 32'd0);
        chk({tag, " rst ll1"}, 32'(ll1), 32'd1);
    endtask

    // Streams img in raster order; duty in percent. abort_at >= 0 pulses
    // reset when that many pixels have been sent.
    task automatic send_frame(input int duty, input int abort_at);
        int n = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (abort_at >= 0 && n == abort_at) begin
                    in_ready = 1'b0;
                    rst = 1'b0;
                    chk_reset_state("midframe");
                    repeat (2) @(posedge clk);
                    #1 rst = 1'b1;
                    return;
                end
                while (int'($urandom_range(1, 100)) > duty) begin
                    in_ready = 1'b0;
                    pixel_in = 4'($urandom);
                    @(posedge clk); #1;
                end
                in_ready = 1'b1;
                pixel_in = img[y][x];
                @(posedge clk); #1;
                n++;
            end
        end
        in_ready = 1'b0;
        pixel_in = 4'd0;
    endtask

    task automatic check_frame(input string tag, input int b0, input int b1,
                               input logic [NR*CW-1:0] ecx0, input logic [NR-1:0] ef0,
                               input int ehd0, input logic ell0,
                               input logic [NR*CW-1:0] ecx1, input logic [NR-1:0] ef1,
                               input int ehd1, input logic ell1);
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk({tag, " u0 frame_valid count"}, 32'(fvc0 - b0), 32'd1);
        chk({tag, " u0 centroid_x"}, 32'(cap_cx0), 32'(ecx0));
        chk({tag, " u0 roi_found"},  32'(cap_f0), 32'(ef0));
        chk({tag, " u0 heading"},    sx(cap_hd0), 32'(ehd0));
        chk({tag, " u0 line_lost"},  32'(cap_ll0), 32'(ell0));
        chk({tag, " u0 held centroid_x"}, 32'(cx0), 32'(ecx0));
        chk({tag, " u1 frame_valid count"}, 32'(fvc1 - b1), 32'd1);
        chk({tag, " u1 centroid_x"}, 32'(cap_cx1), 32'(ecx1));
        chk({tag, " u1 roi_found"},  32'(cap_f1), 32'(ef1));
        chk({tag, " u1 heading"},    sx(cap_hd1), 32'(ehd1));
        chk({tag, " u1 line_lost"},  32'(cap_ll1), 32'(ell1));
        chk({tag, " u1 held roi_found"}, 32'(f1), 32'(ef1));
    endtask

    initial begin
        int b0, b1, ehd0, ehd1;
        logic [NR*CW-1:0] ecx0, ecx1;
        logic [NR-1:0] ef0, ef1;
        logic ell0, ell1;

        tbl[0] = '{0, pack4(15,15,15,15), 4'b1111, 0,  1'b0, pack4(15,15,15,15), 4'b1111, 0,  1'b0};
        tbl[1] = '{1, pack4(0,0,0,0),     4'b0000, 0,  1'b1, pack4(0,0,0,0),     4'b0000, 0,  1'b1};
        tbl[2] = '{2, pack4(27,0,0,5),    4'b1001, 22, 1'b0, pack4(27,0,0,5),    4'b1001, 22, 1'b0};
        tbl[3] = '{3, pack4(0,0,0,15),    4'b0001, 0,  1'b0, pack4(0,0,0,12),    4'b0001, 0,  1'b0};
        tbl[4] = '{4, pack4(9,0,0,0),     4'b1000, 0,  1'b0, pack4(0,0,4,0),     4'b0010, 0,  1'b0};

        repeat (2) @(posedge clk);
        chk_reset_state("power-on");
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk); #1;

        // Directed table, full-rate input.
        for (int i = 0; i < 5; i++) begin
            build_pattern(tbl[i].pat);
            b0 = fvc0; b1 = fvc1;
            send_frame(100, -1);
            check_frame($sformatf("table%0d", i), b0, b1,
                        tbl[i].ecx0, tbl[i].ef0, tbl[i].ehd0, tbl[i].ell0,
                        tbl[i].ecx1, tbl[i].ef1, tbl[i].ehd1, tbl[i].ell1);
        end

        // Same band-wide stripe with roughly half the cycles idle.
        build_pattern(0);
        b0 = fvc0; b1 = fvc1;
        send_frame(50, -1);
        check_frame("gaps", b0, b1, tbl[0].ecx0, tbl[0].ef0, tbl[0].ehd0, tbl[0].ell0,
                    tbl[0].ecx1, tbl[0].ef1, tbl[0].ehd1, tbl[0].ell1);

        // Reset part-way into a frame: no publish for it, next full frame is clean.
        build_pattern(2);
        b0 = fvc0; b1 = fvc1;
        send_frame(50, 400);
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("interrupted u0 no frame_valid", 32'(fvc0 - b0), 32'd0);
        chk("interrupted u1 no frame_valid", 32'(fvc1 - b1), 32'd0);
        @(posedge clk); #1;
        b0 = fvc0; b1 = fvc1;
        send_frame(70, -1);
        check_frame("after-reset", b0, b1, tbl[2].ecx0, tbl[2].ef0, tbl[2].ehd0, tbl[2].ell0,
                    tbl[2].ecx1, tbl[2].ef1, tbl[2].ehd1, tbl[2].ell1);

        // Random sparse frames against the reference model.
        for (int t = 0; t < 5; t++) begin
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    img[y][x] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            model(3, 1'b0, 1,  ecx0, ef0, ehd0, ell0);
            model(0, 1'b1, 10, ecx1, ef1, ehd1, ell1);
            b0 = fvc0; b1 = fvc1;
            send_frame(int'($urandom_range(30, 100)), -1);
            check_frame($sformatf("random%0d", t), b0, b1, ecx0, ef0, ehd0, ell0,
                        ecx1, ef1, ehd1, ell1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
